dm_cache_ctrl: RTL and testbench

DM_CACHE_CTRL -- requirements
Module: dm_cache_ctrl

---
 rtl/dm_cache_ctrl_if.sv | 29 ++
 rtl/dm_cache_ctrl.sv | 151 +++++++++++++++
 tb/tb_dm_cache_ctrl.sv | 391 +++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dm_cache_ctrl_if.sv
// Bus bundle for dm_cache_ctrl: CPU request/response channel plus line-refill memory channel.
// slave is the cache controller's view; master is the CPU/memory environment's view.
interface dm_cache_ctrl_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req_valid;
  logic [ADDR_W-1:0] req_addr;
  logic              req_ready;
  logic              flush;
  logic              resp_valid;
  logic              resp_hit;
  logic [DATA_W-1:0] resp_data;
  logic              mem_req_valid;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_req_ready;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;

  modport slave (
    input  req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    output req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
  );

  modport master (
    output req_valid, req_addr, flush, mem_req_ready, mem_resp_valid, mem_resp_data,
    input  req_ready, resp_valid, resp_hit, resp_data, mem_req_valid, mem_req_addr
  );
endinterface

// File: rtl/dm_cache_ctrl.sv
// Read-only direct-mapped cache controller with whole-line refill and single-cycle flush.
// Define DM_CACHE_STATS_EN to add saturating 32-bit hit_count / miss_count outputs.
module dm_cache_ctrl #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int INDEX_W  = 8,
  parameter int OFFSET_W = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  dm_cache_ctrl_if.slave       bus
`ifdef DM_CACHE_STATS_EN
  ,
  output logic [31:0]          hit_count,
  output logic [31:0]          miss_count
`endif
);

  localparam int TAG_W = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES = 1 << INDEX_W;
  localparam int WORDS = 1 << OFFSET_W;

  typedef enum logic [2:0] {IDLE, LOOKUP, MEMREQ, REFILL, RESPOND} state_t;

  state_t                      state_q, state_d;
  logic [ADDR_W-1:0]           addr_q;
  logic [LINES-1:0]            valid_q;
  logic [OFFSET_W-1:0]         beat_cnt_q;
  logic [DATA_W-1:0]           fill_word_q;
  logic                        resp_valid_q, resp_hit_q;
  logic [DATA_W-1:0]           resp_data_q;
  logic                        mem_req_valid_q;
  logic [ADDR_W-1:0]           mem_req_addr_q;

  logic [TAG_W-1:0]            tag_mem  [LINES];
  logic [DATA_W-1:0]           data_mem [LINES*WORDS];

  logic [TAG_W-1:0]            req_tag;
  logic [INDEX_W-1:0]          req_index;
  logic [OFFSET_W-1:0]         req_offset;
  logic                        accept, do_flush, hit, beat_fire, last_beat;

  assign req_tag    = addr_q[ADDR_W-1 -: TAG_W];
  assign req_index  = addr_q[OFFSET_W +: INDEX_W];
  assign req_offset = addr_q[OFFSET_W-1:0];

  assign accept    = (state_q == IDLE) && bus.req_valid && !bus.flush;
  assign do_flush  = (state_q == IDLE) && bus.flush;
  assign hit       = valid_q[req_index] && (tag_mem[req_index] == req_tag);
  assign beat_fire = (state_q == REFILL) && bus.mem_resp_valid;
  assign last_beat = (beat_cnt_q == {OFFSET_W{1'b1}});

  assign bus.req_ready     = (state_q == IDLE) && !bus.flush;
  assign bus.resp_valid    = resp_valid_q;
  assign bus.resp_hit      = resp_hit_q;
  assign bus.resp_data     = resp_data_q;
  assign bus.mem_req_valid = mem_req_valid_q;
  assign bus.mem_req_addr  = mem_req_addr_q;

  // NOTE: every flop uses <= so all of them sample the pre-edge values regardless of block order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: state_d is given its default before the case so no path can leave it unassigned (no latch).
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept) state_d = LOOKUP;
      LOOKUP:  state_d = hit ? IDLE : MEMREQ;
      MEMREQ:  if (bus.mem_req_ready) state_d = REFILL;
      REFILL:  if (beat_fire && last_beat) state_d = RESPOND;
      RESPOND: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q          <= '0;
      valid_q         <= '0;
      beat_cnt_q      <= '0;
      fill_word_q     <= '0;
      resp_valid_q    <= 1'b0;
      resp_hit_q      <= 1'b0;
      resp_data_q     <= '0;
      mem_req_valid_q <= 1'b0;
      mem_req_addr_q  <= '0;
    end else begin
      resp_valid_q <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (do_flush)    valid_q <= '0;
          else if (accept) addr_q  <= bus.req_addr;
        end
        LOOKUP: begin
          if (hit) begin
            resp_valid_q <= 1'b1;
            resp_hit_q   <= 1'b1;
            resp_data_q  <= data_mem[{req_index, req_offset}];
          end else begin
            // The victim's words get overwritten during refill, so drop it now.
            valid_q[req_index] <= 1'b0;
            mem_req_valid_q    <= 1'b1;
            mem_req_addr_q     <= {addr_q[ADDR_W-1:OFFSET_W], {OFFSET_W{1'b0}}};
          end
        end
        MEMREQ: begin
          if (bus.mem_req_ready) mem_req_valid_q <= 1'b0;
        end
        REFILL: begin
          if (beat_fire) begin
            beat_cnt_q <= beat_cnt_q + OFFSET_W'(1);
            // Capturing the requested word as it streams past covers the last-beat case too.
            if (beat_cnt_q == req_offset) fill_word_q <= bus.mem_resp_data;
            if (last_beat) valid_q[req_index] <= 1'b1;
          end
        end
        RESPOND: begin
          resp_valid_q <= 1'b1;
          resp_hit_q   <= 1'b0;
          resp_data_q  <= fill_word_q;
        end
        default: ;
      endcase
    end
  end

  // NOTE: tag/data arrays carry no reset so they map onto plain RAM; valid_q gates every use.
  always_ff @(posedge clk) begin
    if (beat_fire)              data_mem[{req_index, beat_cnt_q}] <= bus.mem_resp_data;
    if (beat_fire && last_beat) tag_mem[req_index]                <= req_tag;
  end

`ifdef DM_CACHE_STATS_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_count  <= '0;
      miss_count <= '0;
    end else if (resp_valid_q) begin
      if (resp_hit_q) begin
        if (hit_count != '1) hit_count <= hit_count + 32'd1;
      end else begin
        if (miss_count != '1) miss_count <= miss_count + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_dm_cache_ctrl.sv
// Scoreboard bench for dm_cache_ctrl: a line-refill memory model returns data = word address,
// a reference tag/valid model predicts hit/miss, and a monitor pops expectations on resp_valid.
module tb_dm_cache_ctrl;
  localparam int ADDR_W   = 32;
  localparam int DATA_W   = 32;
  localparam int INDEX_W  = 8;
  localparam int OFFSET_W = 4;
  localparam int TAG_W    = ADDR_W - INDEX_W - OFFSET_W;
  localparam int LINES    = 1 << INDEX_W;
  localparam int WORDS    = 1 << OFFSET_W;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  dm_cache_ctrl_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

`ifdef DM_CACHE_STATS_EN
  logic [31:0] hit_count, miss_count;
`endif

  dm_cache_ctrl #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .INDEX_W(INDEX_W), .OFFSET_W(OFFSET_W)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
`ifdef DM_CACHE_STATS_EN
    ,
    .hit_count  (hit_count),
    .miss_count (miss_count)
`endif
  );

  typedef struct packed {
    logic              hit;
    logic [DATA_W-1:0] data;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int          vectors     = 0;
  int          miscompares = 0;

  // Reference model of the cache directory
  bit                 valid_m [LINES];
  logic [TAG_W-1:0]   tag_m   [LINES];
  int                 exp_hits, exp_misses, exp_mem_reqs;

  // Memory model state
  int          beat_limit = WORDS;
  bit          stray_en   = 1'b0;
  bit          m_busy     = 1'b0;
  bit          m_seen     = 1'b0;
  int          m_beats    = 0;
  int          mem_reqs   = 0;
  logic [31:0] m_addr     = '0;

  // Memory: grants refill requests after a random delay, then streams beats with random gaps.
  initial begin
    bus.mem_req_ready  = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data  = '0;
    forever begin
      @(posedge clk); #1;
      bus.mem_req_ready  = 1'b0;
      bus.mem_resp_valid = 1'b0;
      if (rst_n !== 1'b1) begin
        m_busy = 1'b0;
        m_seen = 1'b0;
      end else if (!m_busy) begin
        if (bus.mem_req_valid === 1'b1) begin
          if (!m_seen) begin
            m_seen = 1'b1;
            m_addr = bus.mem_req_addr;
            mem_reqs++;
          end else begin
            vectors++;
            if (bus.mem_req_addr !== m_addr) begin
              miscompares++;
              $display("FAIL mem_req_addr_stable: got %h, required %h", bus.mem_req_addr, m_addr);
            end
          end
          if ($urandom_range(0, 1) == 1) begin
            bus.mem_req_ready = 1'b1;
            m_busy  = 1'b1;
            m_seen  = 1'b0;
            m_beats = 0;
          end
        end else if (stray_en) begin
          bus.mem_resp_valid = 1'b1;
          bus.mem_resp_data  = 32'hDEAD_0000 | 32'($urandom_range(0, 65535));
        end
      end else if (m_beats < beat_limit && $urandom_range(0, 3) != 0) begin
        bus.mem_resp_valid = 1'b1;
        bus.mem_resp_data  = m_addr + 32'(m_beats);
        m_beats++;
        if (m_beats == WORDS) m_busy = 1'b0;
      end
    end
  end

  // Response monitor
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n === 1'b1 && bus.resp_valid === 1'b1) begin
        vectors++;
        if (sb_q.size() == 0) begin
          miscompares++;
          $display("FAIL resp_unexpected: resp_valid=1 data=%h, required no response", bus.resp_data);
        end else begin
          mon_e = sb_q.pop_front();
          if (bus.resp_hit !== mon_e.hit || bus.resp_data !== mon_e.data) begin
            miscompares++;
            $display("FAIL resp: hit=%0b data=%h, required hit=%0b data=%h",
                     bus.resp_hit, bus.resp_data, mon_e.hit, mon_e.data);
          end
        end
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  task automatic clear_model();
    for (int i = 0; i < LINES; i++) valid_m[i] = 1'b0;
  endtask

  // Drives one request from posedge+1, pushes the prediction at the accepting edge.
  task automatic send_req(input logic [31:0] addr);
    int                 budget;
    logic [INDEX_W-1:0] idx;
    logic [TAG_W-1:0]   tag;
    bit                 h;
    idx = addr[OFFSET_W +: INDEX_W];
    tag = addr[ADDR_W-1 -: TAG_W];
    bus.req_valid = 1'b1;
    bus.req_addr  = addr;
    budget = 0;
    do begin
      @(negedge clk);
      budget++;
    end while (bus.req_ready !== 1'b1 && budget < 200);
    if (bus.req_ready !== 1'b1) begin
      vectors++;
      miscompares++;
      $display("FAIL accept_timeout: req_ready=%b for %h, required 1", bus.req_ready, addr);
    end else begin
      h = valid_m[idx] && (tag_m[idx] == tag);
      sb_q.push_back(exp_t'{hit: h, data: addr});
      if (h) exp_hits++;
      else begin
        exp_misses++;
        exp_mem_reqs++;
        valid_m[idx] = 1'b1;
        tag_m[idx]   = tag;
      end
    end
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int budget = 0;
    while (sb_q.size() != 0 && budget < 400) begin
      @(negedge clk);
      budget++;
    end
    if (sb_q.size() != 0) begin
      vectors++;
      miscompares++;
      $display("FAIL %s_timeout: %0d responses outstanding, required 0", name, sb_q.size());
      sb_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 1'b0) begin miscompares++; $display("FAIL rst_resp_valid: got %b, required 0", bus.resp_valid); end
    vectors++;
    if (bus.resp_hit !== 1'b0) begin miscompares++; $display("FAIL rst_resp_hit: got %b, required 0", bus.resp_hit); end
    vectors++;
    if (bus.resp_data !== 32'h0) begin miscompares++; $display("FAIL rst_resp_data: got %h, required 0", bus.resp_data); end
    vectors++;
    if (bus.mem_req_valid !== 1'b0) begin miscompares++; $display("FAIL rst_mem_req_valid: got %b, required 0", bus.mem_req_valid); end
    vectors++;
    if (bus.mem_req_addr !== 32'h0) begin miscompares++; $display("FAIL rst_mem_req_addr: got %h, required 0", bus.mem_req_addr); end
    vectors++;
    if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL rst_req_ready: got %b, required 1", bus.req_ready); end
`ifdef DM_CACHE_STATS_EN
    vectors++;
    if (hit_count !== 32'd0 || miss_count !== 32'd0) begin
      miscompares++;
      $display("FAIL rst_counts: hit=%0d miss=%0d, required 0/0", hit_count, miss_count);
    end
`endif
    clear_model();
    exp_hits   = 0;
    exp_misses = 0;
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic test_cold_miss();
    int base = mem_reqs;
    send_req(32'h0000_1234);
    wait_drain("cold_miss");
    vectors++;
    if (mem_reqs !== base + 1) begin miscompares++; $display("FAIL cold_mem_reqs: got %0d, required %0d", mem_reqs - base, 1); end
    vectors++;
    if (m_addr !== 32'h0000_1230) begin miscompares++; $display("FAIL cold_mem_addr: got %h, required 00001230", m_addr); end
  endtask

  task automatic test_hit();
    int base = mem_reqs;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1235;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b1) begin miscompares++; $display("FAIL hit_ready: got %b, required 1", bus.req_ready); end
    sb_q.push_back(exp_t'{hit: 1'b1, data: 32'h0000_1235});
    exp_hits++;
    @(posedge clk); #1;
    bus.req_valid = 1'b0;
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 1'b0 || bus.mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_latency_e0: resp_valid=%b mem_req_valid=%b, required 0/0", bus.resp_valid, bus.mem_req_valid);
    end
    @(negedge clk);
    vectors++;
    if (bus.resp_valid !== 1'b1 || bus.mem_req_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL hit_latency_e1: resp_valid=%b mem_req_valid=%b, required 1/0", bus.resp_valid, bus.mem_req_valid);
    end
    wait_drain("hit");
    vectors++;
    if (mem_reqs !== base) begin miscompares++; $display("FAIL hit_mem_reqs: got %0d, required 0", mem_reqs - base); end
  endtask

  task automatic test_conflict();
    int base = mem_reqs;
    send_req(32'h0000_2234);
    send_req(32'h0000_1234);
    wait_drain("conflict");
    vectors++;
    if (mem_reqs !== base + 2) begin miscompares++; $display("FAIL conflict_mem_reqs: got %0d, required 2", mem_reqs - base); end
`ifdef DM_CACHE_STATS_EN
    vectors++;
    if (hit_count !== 32'd1 || miss_count !== 32'd3) begin
      miscompares++;
      $display("FAIL conflict_counts: hit=%0d miss=%0d, required 1/3", hit_count, miss_count);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int off = 0; off < WORDS; off++) send_req(32'h0000_1230 + 32'(off));
    for (int i = 0; i < 24; i++) begin
      logic [31:0] a;
      a = {20'($urandom_range(1, 3)), 8'(8'h40 + $urandom_range(0, 1)), 4'($urandom_range(0, 15))};
      send_req(a);
    end
    wait_drain("back_to_back");
    vectors++;
    if (mem_reqs !== exp_mem_reqs) begin miscompares++; $display("FAIL b2b_mem_reqs: got %0d, required %0d", mem_reqs, exp_mem_reqs); end
  endtask

  task automatic test_flush();
    // Flush during a refill must be ignored: the unrelated line 0x123 survives.
    send_req(32'h0000_5550);
    repeat (3) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    wait_drain("flush_busy");
    send_req(32'h0000_1236);
    send_req(32'h0000_5551);
    wait_drain("flush_busy_hits");
    // Flush in IDLE wins over a same-cycle request.
    bus.flush     = 1'b1;
    bus.req_valid = 1'b1;
    bus.req_addr  = 32'h0000_1234;
    @(negedge clk);
    vectors++;
    if (bus.req_ready !== 1'b0) begin miscompares++; $display("FAIL flush_req_ready: got %b, required 0", bus.req_ready); end
    clear_model();
    @(posedge clk); #1;
    bus.flush = 1'b0;
    send_req(32'h0000_1234);
    send_req(32'h0000_5552);
    wait_drain("flush_idle");
    vectors++;
    if (mem_reqs !== exp_mem_reqs) begin miscompares++; $display("FAIL flush_mem_reqs: got %0d, required %0d", mem_reqs, exp_mem_reqs); end
`ifdef DM_CACHE_STATS_EN
    vectors++;
    if (hit_count !== 32'(exp_hits) || miss_count !== 32'(exp_misses)) begin
      miscompares++;
      $display("FAIL flush_counts: hit=%0d miss=%0d, required %0d/%0d", hit_count, miss_count, exp_hits, exp_misses);
    end
`endif
  endtask

  task automatic test_stray_beats();
    stray_en = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    send_req(32'h0000_1237);
    send_req(32'h0000_9990);
    send_req(32'h0000_999F);
    send_req(32'h0000_9995);
    wait_drain("stray_beats");
    stray_en = 1'b0;
  endtask

  task automatic test_reset_mid_refill();
    int budget = 0;
    beat_limit = 6;
    send_req(32'h0000_7003);
    while (!(m_busy && m_beats == 6) && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    vectors++;
    if (!(m_busy && m_beats == 6)) begin
      miscompares++;
      $display("FAIL midfill_beats_timeout: beats=%0d busy=%0b, required 6/1", m_beats, m_busy);
    end
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    vectors++;
    if (bus.mem_req_valid !== 1'b0 || bus.resp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midfill_reset: mem_req_valid=%b resp_valid=%b req_ready=%b, required 0/0/1",
               bus.mem_req_valid, bus.resp_valid, bus.req_ready);
    end
    sb_q.delete();
    clear_model();
    exp_hits   = 0;
    exp_misses = 0;
    repeat (2) @(posedge clk);
    #1;
    rst_n      = 1'b1;
    beat_limit = WORDS;
    repeat (20) @(posedge clk);
    #1;
    send_req(32'h0000_7003);
    send_req(32'h0000_1234);
    send_req(32'h0000_7004);
    wait_drain("midfill_rerequest");
    vectors++;
    if (mem_reqs !== exp_mem_reqs) begin miscompares++; $display("FAIL midfill_mem_reqs: got %0d, required %0d", mem_reqs, exp_mem_reqs); end
`ifdef DM_CACHE_STATS_EN
    vectors++;
    if (hit_count !== 32'd1 || miss_count !== 32'd2) begin
      miscompares++;
      $display("FAIL midfill_counts: hit=%0d miss=%0d, required 1/2", hit_count, miss_count);
    end
`endif
  endtask

  initial begin
    bus.req_valid = 1'b0;
    bus.req_addr  = '0;
    bus.flush     = 1'b0;
    rst_n         = 1'b0;
    exp_mem_reqs  = 0;
    clear_model();
    test_reset();
    test_cold_miss();
    test_hit();
    test_conflict();
    test_back_to_back();
    test_flush();
    test_stray_beats();
    test_reset_mid_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
